// File: rtl/mul_serial_host.sv
// mul_serial_host
//   Host-side sequencer for a bit-serial signed multiplier. It takes one pair
//   of parallel operands over a valid/ready handshake and shifts them LSB-first
//   into the multiplier. It then requests the multiply, shifts the product
//   back out LSB-first and presents it as a parallel result over a valid/ready
//   handshake. A watchdog bounds every wait on the multiplier.
//
// Ports
//   Clk, reset          : clock (rising edge), asynchronous active-low reset
//   op_valid/op_ready   : operand handshake; op_x/op_y are raw two's complement
//   X_in/Sx, Y_in/Sy    : serial operand data and shift enables
//   Fx, Fy              : multiplier reports operand load finished
//   Mul/Don             : multiply request / done
//   Sz/Z_out/Fz         : product shift enable, serial product bit, shift done
//   res_valid/res_ready : result handshake, res_z holds the product
//   err                 : sticky watchdog flag
module mul_serial_host #(
  parameter int X_WIDTH   = 8,
  parameter int Y_WIDTH   = 8,
  parameter int Z_WIDTH   = X_WIDTH + Y_WIDTH,
  parameter int CNT_WIDTH = 5,
  parameter int Z_LAT     = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [X_WIDTH-1:0] op_x,
  input  logic [Y_WIDTH-1:0] op_y,
  output logic               X_in,
  output logic               Sx,
  output logic               Y_in,
  output logic               Sy,
  input  logic               Fx,
  input  logic               Fy,
  output logic               Mul,
  input  logic               Don,
  output logic               Sz,
  input  logic               Z_out,
  input  logic               Fz,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [Z_WIDTH-1:0] res_z,
  output logic               err
);

  localparam int XY_MAX   = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

  localparam logic [CNT_WIDTH-1:0] X_LAST  = CNT_WIDTH'(X_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST  = CNT_WIDTH'(Y_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] XY_LAST = CNT_WIDTH'(XY_MAX - 1);
  localparam logic [CNT_WIDTH-1:0] Z_FIRST = CNT_WIDTH'(Z_LAT);
  localparam logic [CNT_WIDTH-1:0] Z_LAST  = CNT_WIDTH'(Z_WIDTH + Z_LAT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [WD_WIDTH-1:0]  WD_LAST = WD_WIDTH'(TIMEOUT - 1);
  localparam logic [WD_WIDTH-1:0]  WD_ONE  = WD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_XY = 3'd1,
    S_WAIT_F   = 3'd2,
    S_MUL      = 3'd3,
    S_SHIFT_Z  = 3'd4,
    S_WAIT_FZ  = 3'd5,
    S_RESULT   = 3'd6
  } state_t;

  state_t               r_state;
  logic [X_WIDTH-1:0]   r_x;        // operand bits not yet presented on X_in
  logic [Y_WIDTH-1:0]   r_y;
  logic [Z_WIDTH-1:0]   r_z;        // product assembled MSB-in, ends LSB-aligned
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WD_WIDTH-1:0]  r_wd;
  logic                 r_fx_seen;
  logic                 r_fy_seen;
  logic                 r_fz_seen;

  logic                 w_fxy_done;
  logic                 w_fz_done;
  logic                 w_wd_expired;
  logic [Z_WIDTH-1:0]   w_z_nxt;

  // Fx/Fy/Fz may pulse before the host is looking, so a latched sighting counts.
  assign w_fxy_done   = (r_fx_seen | Fx) & (r_fy_seen | Fy);
  assign w_fz_done    = r_fz_seen | Fz;
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_z_nxt      = {Z_out, r_z[Z_WIDTH-1:1]};

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_fx_seen <= 1'b0;
      r_fy_seen <= 1'b0;
      r_fz_seen <= 1'b0;
      op_ready  <= 1'b1;
      X_in      <= 1'b0;
      Sx        <= 1'b0;
      Y_in      <= 1'b0;
      Sy        <= 1'b0;
      Mul       <= 1'b0;
      Sz        <= 1'b0;
      res_valid <= 1'b0;
      res_z     <= '0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            // Bit 0 goes straight onto the pins; the rest wait in r_x/r_y.
            op_ready  <= 1'b0;
            X_in      <= op_x[0];
            Sx        <= 1'b1;
            r_x       <= op_x >> 1;
            Y_in      <= op_y[0];
            Sy        <= 1'b1;
            r_y       <= op_y >> 1;
            r_cnt     <= '0;
            r_fx_seen <= 1'b0;
            r_fy_seen <= 1'b0;
            r_state   <= S_SHIFT_XY;
          end else begin
            op_ready <= 1'b1;
          end
        end

        S_SHIFT_XY: begin
          // r_cnt is the index of the bit the multiplier takes at this edge.
          r_cnt     <= r_cnt + CNT_ONE;
          r_fx_seen <= r_fx_seen | Fx;
          r_fy_seen <= r_fy_seen | Fy;
          if (r_cnt < X_LAST) begin
            X_in <= r_x[0];
            r_x  <= r_x >> 1;
            Sx   <= 1'b1;
          end else begin
            X_in <= 1'b0;
            Sx   <= 1'b0;
          end
          if (r_cnt < Y_LAST) begin
            Y_in <= r_y[0];
            r_y  <= r_y >> 1;
            Sy   <= 1'b1;
          end else begin
            Y_in <= 1'b0;
            Sy   <= 1'b0;
          end
          if (r_cnt == XY_LAST) begin
            r_wd    <= '0;
            r_state <= S_WAIT_F;
          end
        end

        S_WAIT_F: begin
          r_fx_seen <= r_fx_seen | Fx;
          r_fy_seen <= r_fy_seen | Fy;
          if (w_fxy_done) begin
            Mul     <= 1'b1;
            r_wd    <= '0;
            r_state <= S_MUL;
          end else if (w_wd_expired) begin
            err      <= 1'b1;
            op_ready <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end

        S_MUL: begin
          if (Don) begin
            Mul       <= 1'b0;
            Sz        <= 1'b1;
            r_cnt     <= '0;
            r_fz_seen <= 1'b0;
            r_state   <= S_SHIFT_Z;
          end else if (w_wd_expired) begin
            err      <= 1'b1;
            Mul      <= 1'b0;
            op_ready <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end

        S_SHIFT_Z: begin
          // Edges before Z_FIRST only cover the multiplier's output latency.
          r_cnt     <= r_cnt + CNT_ONE;
          r_fz_seen <= w_fz_done;
          if (r_cnt >= Z_FIRST) begin
            r_z <= w_z_nxt;
          end
          if (r_cnt == Z_LAST) begin
            Sz <= 1'b0;
            if (w_fz_done) begin
              res_z     <= w_z_nxt;
              res_valid <= 1'b1;
              r_state   <= S_RESULT;
            end else begin
              r_wd    <= '0;
              r_state <= S_WAIT_FZ;
            end
          end
        end

        S_WAIT_FZ: begin
          if (Fz) begin
            res_z     <= r_z;
            res_valid <= 1'b1;
            r_state   <= S_RESULT;
          end else if (w_wd_expired) begin
            err      <= 1'b1;
            Sz       <= 1'b0;
            op_ready <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          X_in      <= 1'b0;
          Sx        <= 1'b0;
          Y_in      <= 1'b0;
          Sy        <= 1'b0;
          Mul       <= 1'b0;
          Sz        <= 1'b0;
          res_valid <= 1'b0;
          op_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_serial_host.sv
// Bench for mul_serial_host: behavioural serial multiplier, expected-result
// queue filled by the stimulus, and a monitor that checks each result handshake.
module tb_mul_serial_host;

  localparam int TO = 64;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_x = 8'h00;
  logic [7:0]  op_y = 8'h00;
  logic        X_in, Sx, Y_in, Sy;
  logic        Fx, Fy, Mul, Don, Sz, Z_out, Fz;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_z;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  bit          no_don = 1'b0;

  always #5 Clk = ~Clk;

  mul_serial_host #(.X_WIDTH(8), .Y_WIDTH(8), .Z_WIDTH(16), .CNT_WIDTH(5),
                    .Z_LAT(1), .TIMEOUT(TO)) dut (
    .Clk(Clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_x(op_x), .op_y(op_y), .X_in(X_in), .Sx(Sx), .Y_in(Y_in), .Sy(Sy),
    .Fx(Fx), .Fy(Fy), .Mul(Mul), .Don(Don), .Sz(Sz), .Z_out(Z_out), .Fz(Fz),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural serial multiplier ----------------
  logic [7:0]         mx, my;
  logic [4:0]         xc, yc, zc;
  logic [15:0]        zsh;
  logic signed [15:0] sx16, sy16, prod;
  assign sx16 = 16'($signed(mx));
  assign sy16 = 16'($signed(my));
  assign prod = sx16 * sy16;

  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      mx <= 8'h00; my <= 8'h00; xc <= 5'd0; yc <= 5'd0; zc <= 5'd0;
      zsh <= 16'h0000; Fx <= 1'b0; Fy <= 1'b0; Don <= 1'b0;
      Z_out <= 1'b0; Fz <= 1'b0;
    end else begin
      if (Sx) begin
        mx <= {X_in, mx[7:1]}; xc <= xc + 5'd1;
        if (xc == 5'd7) Fx <= 1'b1;
      end
      if (Sy) begin
        my <= {Y_in, my[7:1]}; yc <= yc + 5'd1;
        if (yc == 5'd7) Fy <= 1'b1;
      end
      if (Mul) begin
        Fx <= 1'b0; Fy <= 1'b0; xc <= 5'd0; yc <= 5'd0;
      end
      Don <= Mul && !Don && !no_don;
      if (Mul && !Don && !no_don) begin
        zsh <= prod; zc <= 5'd0; Fz <= 1'b0;
      end
      if (Sz) begin
        Z_out <= zsh[0]; zsh <= zsh >> 1; zc <= zc + 5'd1;
        if (zc == 5'd15) Fz <= 1'b1;
      end
    end
  end

  // ---------------- serial operand recorder ----------------
  logic [7:0] xrec = 8'h00, yrec = 8'h00;
  int         sxc = 0, syc = 0;
  always @(negedge Clk) begin
    if (op_valid && op_ready) begin
      xrec = 8'h00; yrec = 8'h00; sxc = 0; syc = 0;
    end
    if (Sx) begin xrec = {X_in, xrec[7:1]}; sxc++; end
    if (Sy) begin yrec = {Y_in, yrec[7:1]}; syc++; end
  end

  // ---------------- result monitor / scoreboard ----------------
  bit          hs_prev = 1'b0;
  logic [15:0] exp_z;
  always @(negedge Clk) begin
    if (hs_prev) begin
      chk("op_ready_after_hs", 32'(op_ready), 32'd1);
      chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    end
    hs_prev = 1'b0;
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got res_z=0x%0h, expected no result", res_z);
      end else begin
        exp_z = exp_q.pop_front();
        chk("res_z", 32'(res_z), 32'(exp_z));
      end
      hs_prev = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_state(input string tag);
    chk({tag, "_outs"}, 32'({op_ready, X_in, Sx, Y_in, Sy, Mul, Sz, res_valid, err}),
        32'b1_0000_0000);
    chk({tag, "_res_z"}, 32'(res_z), 32'd0);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(posedge Clk); #1;
    op_valid = 1'b1; op_x = x; op_y = y;
    while (!op_ready && n < 300) begin @(posedge Clk); #1; n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL send_accept: op_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge Clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && op_ready) && n < 600) begin @(posedge Clk); #1; n++; end
    if (n >= 600) begin
      checks++; failures++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", tag, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exhausted, expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] z0;

    // reset state
    repeat (3) @(posedge Clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;
    @(posedge Clk); #1;
    chk("idle_op_ready", 32'(op_ready), 32'd1);

    // 3*5 with the result held off for 20 cycles while new operands are offered
    exp_q.push_back(16'h000F);
    send(8'h03, 8'h05);
    n = 0;
    while (!res_valid && n < 300) begin @(posedge Clk); #1; n++; end
    chk("res_valid_seen", 32'(res_valid), 32'd1);
    chk("x_serial", 32'(xrec), 32'h03);
    chk("sx_cycles", 32'(sxc), 32'd8);
    chk("y_serial", 32'(yrec), 32'h05);
    chk("sy_cycles", 32'(syc), 32'd8);
    chk("hold_res_z", 32'(res_z), 32'h000F);
    z0 = res_z;
    bad = 0;
    op_valid = 1'b1; op_x = 8'h11; op_y = 8'h22;
    repeat (20) begin
      @(posedge Clk); #1;
      if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_z !== z0) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    chk("hold_no_shift", 32'(sxc), 32'd8);
    op_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("t1");

    // -3 * 5
    exp_q.push_back(16'hFFF1);
    send(8'hFD, 8'h05);
    wait_idle("t2");

    // back-to-back: -128*-128, 127*-1
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'hFF81);
    send(8'h80, 8'h80);
    send(8'h7F, 8'hFF);
    wait_idle("t3");

    // Don never comes: watchdog in MUL
    no_don = 1'b1;
    send(8'h03, 8'h05);
    n = 0;
    while (!Mul && n < 100) begin @(posedge Clk); #1; n++; end
    chk("mul_raised", 32'(Mul), 32'd1);
    n = 0;
    while (!err && n < TO + 20) begin @(posedge Clk); #1; n++; end
    chk("wd_cycles", 32'(n), 32'(TO));
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_mul_low", 32'(Mul), 32'd0);
    chk("wd_idle", 32'(op_ready), 32'd1);
    no_don = 1'b0;

    // next transaction still completes, err stays set: 7*6
    exp_q.push_back(16'h002A);
    send(8'h07, 8'h06);
    wait_idle("t5");
    chk("err_sticky", 32'(err), 32'd1);

    // reset during product shift-out, around bit 7
    send(8'h05, 8'h03);
    n = 0;
    while (!Sz && n < 100) begin @(posedge Clk); #1; n++; end
    chk("sz_raised", 32'(Sz), 32'd1);
    repeat (8) begin @(posedge Clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge Clk);
    reset = 1'b1;

    // 2 * -1 after the abandoned transaction
    exp_q.push_back(16'hFFFE);
    send(8'h02, 8'hFF);
    wait_idle("t6");

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_serial_host.md
Name: mul_serial_host

Overview:
- Host-side sequencer placed directly upstream and downstream of the serial signed-multiplier top.
- Accepts one pair of parallel signed operands on a valid/ready handshake.
- Serialises the operands into the X_in/Sx and Y_in/Sy pins, waits for Fx and Fy, then drives Mul until Don.
- Shifts the product out with Sz, reassembles it into a parallel signed result and presents it on a valid/ready handshake.
- Includes a watchdog that flags a multiplier that never reports completion.

Parameters:
- X_WIDTH, 8, operand X width in bits.
- Y_WIDTH, 8, operand Y width in bits.
- Z_WIDTH, X_WIDTH+Y_WIDTH, product width in bits.
- CNT_WIDTH, 5, bit-counter width; must satisfy 2^CNT_WIDTH > max(X_WIDTH, Y_WIDTH, Z_WIDTH+Z_LAT).
- Z_LAT, 1, cycles from the first Sz-high edge to the first valid Z_out bit.
- TIMEOUT, 1023, maximum number of cycles spent waiting in any handshake-wait state.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  host has operands on op_x/op_y.
- op_ready  out  1  block can accept operands.
- op_x  in  X_WIDTH  signed operand X (two's complement).
- op_y  in  Y_WIDTH  signed operand Y (two's complement).
- X_in  out  1  serial X data to the multiplier.
- Sx  out  1  X shift enable.
- Y_in  out  1  serial Y data.
- Sy  out  1  Y shift enable.
- Fx  in  1  X load finished.
- Fy  in  1  Y load finished.
- Mul  out  1  multiply request.
- Don  in  1  multiply done.
- Sz  out  1  Z shift-out enable.
- Z_out  in  1  serial product bit.
- Fz  in  1  Z shift-out finished.
- res_valid  out  1  res_z holds a product.
- res_ready  in  1  host accepts res_z.
- res_z  out  Z_WIDTH  signed product.
- err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. All outputs are 0 except op_ready=1. res_z=0, err=0, all counters cleared. Reset mid-operation abandons the transaction immediately and no partial result is ever presented.
- Bit order: LSB first on X_in, Y_in and Z_out.
- IDLE:
  - op_ready=1.
  - When op_valid & op_ready, capture op_x/op_y into shift registers and clear the bit counter. Next state SHIFT_XY.
  - op_ready drops in the cycle after the accept.
- SHIFT_XY:
  - Sx=1 for exactly X_WIDTH cycles with X_in = current X LSB; the X register shifts right each cycle.
  - Sy=1 for exactly Y_WIDTH cycles, handled the same way with Y_in.
  - X and Y shift concurrently from the first cycle. When widths differ, the shorter enable drops early and its data pin goes to 0.
  - When both counts are complete, go to WAIT_F.
- WAIT_F: wait until Fx & Fy, sampled high together or each latched once seen. Then go to MUL.
- MUL: Mul=1 held until Don is sampled high. Mul drops on the same edge. Next state SHIFT_Z.
- SHIFT_Z:
  - Sz=1 for Z_WIDTH+Z_LAT cycles.
  - Starting at the Z_LAT-th edge after entry, sample Z_out into bit counter k, for k = 0..Z_WIDTH-1.
  - Exit after the last bit is captured and Fz has been seen (latched). Next state RESULT.
- RESULT:
  - res_valid=1 and res_z stable until res_valid & res_ready. Then return to IDLE with op_ready=1 on the next cycle.
  - res_ready is ignored while res_valid=0.
- Watchdog:
  - A cycle counter is cleared on entry to WAIT_F, MUL and the Fz wait.
  - If it reaches TIMEOUT, set err=1 (sticky until reset), force Mul=0 and Sz=0, and go to IDLE without asserting res_valid.
- Throughput: one transaction in flight at a time. A new op_valid in IDLE in the same cycle that RESULT completes is accepted the following cycle.
- Sign handling belongs to the multiplier. This block passes and returns raw two's-complement bits with no arithmetic.

Test Plan:
- op_x=3, op_y=5, multiplier model responds with minimum latency -> X_in sequence 1,1,0,0,0,0,0,0 with Sx high 8 cycles; res_z=0x000F; res_valid held until res_ready.
- op_x=0xFD (-3), op_y=5 -> res_z=0xFFF1 (-15).
- op_x=0x80, op_y=0x80 -> res_z=0x4000. Then op_x=0x7F, op_y=0xFF -> res_z=0xFF81. Run back-to-back with res_ready held high -> op_ready returns 1 the cycle after each result handshake.
- res_ready held low 20 cycles after res_valid -> res_z stable, no new operands accepted (op_ready=0), op_valid ignored.
- Don never asserted -> err=1 after TIMEOUT cycles in MUL, Mul=0, state IDLE, res_valid never 1. Next transaction still completes with err still 1.
- reset pulsed low during SHIFT_Z at bit 7 -> all outputs 0 and op_ready=1 asynchronously. A following 2*(-1)=0xFFFE transaction completes correctly.
